// File: rtl/commu_m_pkgbuf_if.sv
// Signal bundle between the repack stage / ARM side and the package buffer.
interface commu_m_pkgbuf_if;
  logic       repk_frm;
  logic       repk_vld;
  logic [7:0] repk_dat;
  logic       buf_frm;
  logic       buf_rd;
  logic       wd_arm_high;
  logic [7:0] buf_dat;
  logic [8:0] buf_len;
  logic [3:0] cnt_pkg_buf;
  logic       stu_full;
  logic [7:0] ovf_cnt;

  modport master (
    output repk_frm, repk_vld, repk_dat, buf_frm, buf_rd, wd_arm_high,
    input  buf_dat, buf_len, cnt_pkg_buf, stu_full, ovf_cnt
  );

  modport slave (
    input  repk_frm, repk_vld, repk_dat, buf_frm, buf_rd, wd_arm_high,
    output buf_dat, buf_len, cnt_pkg_buf, stu_full, ovf_cnt
  );
endinterface

// File: rtl/commu_m_pkgbuf.sv
// Circular package buffer: captures repacked frames into slots and serves
// ARM byte reads of the oldest package; watchdog pulse discards the oldest.
module commu_m_pkgbuf #(
  parameter int SLOT_NUM = 8,
  parameter int SLOT_AW  = 8
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  commu_m_pkgbuf_if.slave bus
);
  localparam int         SW       = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
  localparam int         LW       = SLOT_AW + 1;
  localparam int         DEPTH    = SLOT_NUM << SLOT_AW;
  localparam logic [3:0] FULL_CNT = 4'(SLOT_NUM);

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wstate_t;
  typedef enum logic       {R_IDLE, R_READ}         rstate_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [SLOT_AW-1:0] sat_inc_byte(input logic [SLOT_AW-1:0] v);
    return (&v) ? v : v + SLOT_AW'(1);
  endfunction

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == SW'(SLOT_NUM - 1)) ? '0 : s + SW'(1);
  endfunction

  logic [7:0]         mem     [DEPTH];
  logic [LW-1:0]      len_mem [SLOT_NUM];

  logic               frm_p0;
  logic               bfrm_p0, bfrm_p1, bfrm_p2;
  logic               brd_p0,  brd_p1,  brd_p2;
  logic               frm_rise, frm_fall, bfrm_rise, bfrm_fall, brd_rise;

  wstate_t            wstate, wstate_nxt;
  rstate_t            rstate, rstate_nxt;
  logic [LW-1:0]      wbyte;
  logic [SW-1:0]      wslot, rslot;
  logic [SLOT_AW-1:0] rbyte;
  logic [3:0]         cnt_pkg, cnt_nxt;
  logic               stu_full_r;
  logic [7:0]         ovf_cnt_r;
  logic [7:0]         buf_dat_r;
  logic               wr_start, wr_en, commit, drop;
  logic               rd_start, rd_adv, release_ev, discard, head_avail;

  // Input capture: frame edge register and ARM-side synchronizers
  // repk edge register resets high so a frame still running across reset is not taken as a new one.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      frm_p0  <= 1'b1;
      bfrm_p0 <= 1'b0;
      bfrm_p1 <= 1'b0;
      bfrm_p2 <= 1'b0;
      brd_p0  <= 1'b0;
      brd_p1  <= 1'b0;
      brd_p2  <= 1'b0;
    end else begin
      frm_p0  <= bus.repk_frm;
      bfrm_p0 <= bus.buf_frm;
      bfrm_p1 <= bfrm_p0;
      bfrm_p2 <= bfrm_p1;
      brd_p0  <= bus.buf_rd;
      brd_p1  <= brd_p0;
      brd_p2  <= brd_p1;
    end
  end

  assign frm_rise  = ~frm_p0 & bus.repk_frm;
  assign frm_fall  = frm_p0 & ~bus.repk_frm;
  assign bfrm_rise = bfrm_p1 & ~bfrm_p2;
  assign bfrm_fall = ~bfrm_p1 & bfrm_p2;
  assign brd_rise  = brd_p1 & ~brd_p2;

  // Write side FSM
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) wstate <= W_IDLE;
    else        wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (frm_rise) wstate_nxt = (cnt_pkg == FULL_CNT) ? W_DROP : W_RECV;
      W_RECV:  if (frm_fall) wstate_nxt = W_IDLE;
      W_DROP:  if (frm_fall) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    wr_start = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
    case (wstate)
      W_IDLE: wr_start = frm_rise && (cnt_pkg != FULL_CNT);
      W_RECV: begin
        // wbyte top bit set means the slot is full; further bytes are dropped
        wr_en  = bus.repk_frm && bus.repk_vld && !wbyte[SLOT_AW];
        commit = frm_fall && (wbyte != '0);
      end
      W_DROP: drop = frm_fall;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wbyte     <= '0;
      wslot     <= '0;
      ovf_cnt_r <= '0;
    end else begin
      if (wr_start)   wbyte <= '0;
      else if (wr_en) wbyte <= wbyte + LW'(1);
      if (commit)     wslot <= slot_inc(wslot);
      if (drop)       ovf_cnt_r <= sat_inc8(ovf_cnt_r);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en)  mem[{wslot, wbyte[SLOT_AW-1:0]}] <= bus.repk_dat;
    if (commit) len_mem[wslot] <= wbyte;
  end

  // Read side FSM
  // A read only starts if a head package survives a same-cycle watchdog discard.
  assign head_avail = (cnt_pkg > {3'b000, bus.wd_arm_high});

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) rstate <= R_IDLE;
    else        rstate <= rstate_nxt;
  end

  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (bfrm_rise && head_avail) rstate_nxt = R_READ;
      R_READ:  if (bfrm_fall) rstate_nxt = R_IDLE;
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_start   = 1'b0;
    rd_adv     = 1'b0;
    release_ev = 1'b0;
    discard    = 1'b0;
    case (rstate)
      R_IDLE: begin
        rd_start = bfrm_rise && head_avail;
        discard  = bus.wd_arm_high && (cnt_pkg != '0);
      end
      R_READ: begin
        rd_adv     = brd_rise;
        release_ev = bfrm_fall;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt_pkg;
    if (commit && !(release_ev || discard))      cnt_nxt = cnt_pkg + 4'd1;
    else if (!commit && (release_ev || discard)) cnt_nxt = cnt_pkg - 4'd1;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rbyte      <= '0;
      rslot      <= '0;
      cnt_pkg    <= '0;
      stu_full_r <= 1'b0;
    end else begin
      if (rd_start)    rbyte <= '0;
      else if (rd_adv) rbyte <= sat_inc_byte(rbyte);
      if (release_ev || discard) rslot <= slot_inc(rslot);
      cnt_pkg    <= cnt_nxt;
      stu_full_r <= (cnt_nxt == FULL_CNT);
    end
  end

  // Output register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                 buf_dat_r <= '0;
    else if (rstate == R_READ)  buf_dat_r <= mem[{rslot, rbyte}];
    else                        buf_dat_r <= '0;
  end

  assign bus.buf_dat     = buf_dat_r;
  assign bus.buf_len     = (cnt_pkg != '0) ? 9'(len_mem[rslot]) : 9'd0;
  assign bus.cnt_pkg_buf = cnt_pkg;
  assign bus.stu_full    = stu_full_r;
  assign bus.ovf_cnt     = ovf_cnt_r;
endmodule

// File: tb/tb_commu_m_pkgbuf.sv
// Randomized bench for commu_m_pkgbuf against a package-queue reference model.
module tb_commu_m_pkgbuf;
  logic clk_sys;
  logic rst_n;
  commu_m_pkgbuf_if bus();

  commu_m_pkgbuf #(.SLOT_NUM(8), .SLOT_AW(8)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int         total = 0;
  int         bad   = 0;
  int         mq[$];
  int         plen  [64];
  logic [7:0] pdat  [64][300];
  int         next_id = 0;
  int         ovf_m   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_cnt"},  int'(bus.cnt_pkg_buf), mq.size());
    chk({tag, "_full"}, int'(bus.stu_full), int'(mq.size() == 8));
    chk({tag, "_len"},  int'(bus.buf_len), (mq.size() > 0) ? plen[mq[0]] : 0);
    chk({tag, "_ovf"},  int'(bus.ovf_cnt), ovf_m);
  endtask

  task automatic send_frame(input int n, input bit wd_end, input bit pat);
    int         id;
    bit         was_full;
    logic [7:0] d;
    id = next_id % 64;
    next_id++;
    was_full = (mq.size() == 8);
    @(negedge clk_sys);
    bus.repk_frm = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < n; i++) begin
      d = pat ? 8'(17 * (i + 1)) : 8'($urandom);
      pdat[id][i] = d;
      bus.repk_vld = 1'b1;
      bus.repk_dat = d;
      @(negedge clk_sys);
      if ($urandom_range(3) == 0) begin
        bus.repk_vld = 1'b0;
        @(negedge clk_sys);
      end
    end
    bus.repk_frm    = 1'b0;
    bus.repk_vld    = 1'($urandom_range(1));
    bus.repk_dat    = 8'($urandom);
    bus.wd_arm_high = wd_end;
    @(negedge clk_sys);
    bus.repk_vld    = 1'b0;
    bus.wd_arm_high = 1'b0;
    if (wd_end && mq.size() > 0) void'(mq.pop_front());
    if (was_full) ovf_m = (ovf_m == 255) ? 255 : ovf_m + 1;
    else if (n > 0) begin
      plen[id] = (n > 256) ? 256 : n;
      mq.push_back(id);
    end
  endtask

  task automatic wd_pulse(input bit reading);
    @(negedge clk_sys);
    bus.wd_arm_high = 1'b1;
    @(negedge clk_sys);
    bus.wd_arm_high = 1'b0;
    if (!reading && mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic arm_open();
    @(negedge clk_sys);
    bus.buf_frm = 1'b1;
    repeat (5) @(negedge clk_sys);
  endtask

  task automatic arm_strobe();
    @(negedge clk_sys);
    bus.buf_rd = 1'b1;
    @(negedge clk_sys);
    bus.buf_rd = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic arm_close(input bit held);
    @(negedge clk_sys);
    bus.buf_frm = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("rel_wait", int'(bus.cnt_pkg_buf), mq.size());
    @(negedge clk_sys);
    if (held) void'(mq.pop_front());
    chk("rel_cnt", int'(bus.cnt_pkg_buf), mq.size());
    @(negedge clk_sys);
    chk("idle_dat", int'(bus.buf_dat), 0);
  endtask

  task automatic read_pkg(input int nread);
    int id;
    arm_open();
    if (mq.size() == 0) begin
      chk("empty_dat", int'(bus.buf_dat), 0);
      arm_close(1'b0);
      return;
    end
    id = mq[0];
    chk("head_len", int'(bus.buf_len), plen[id]);
    chk("byte0", int'(bus.buf_dat), int'(pdat[id][0]));
    for (int k = 1; k < nread; k++) begin
      arm_strobe();
      chk($sformatf("byte%0d", k), int'(bus.buf_dat), int'(pdat[id][k]));
    end
    arm_close(1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int id;
    int op;
    int n;
    rst_n           = 1'b0;
    bus.repk_frm    = 1'b0;
    bus.repk_vld    = 1'b0;
    bus.repk_dat    = 8'h00;
    bus.buf_frm     = 1'b0;
    bus.buf_rd      = 1'b0;
    bus.wd_arm_high = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk("rst_dat", int'(bus.buf_dat), 0);
    check_status("rst");
    rst_n = 1'b1;
    @(negedge clk_sys);

    // basic write/read
    send_frame(4, 1'b0, 1'b1);
    check_status("basic");
    read_pkg(4);
    check_status("basic_done");

    // overflow
    for (int i = 0; i < 9; i++) send_frame(3 + i, 1'b0, 1'b0);
    check_status("ovf");
    read_pkg(plen[mq[0]]);
    while (mq.size() > 0) read_pkg(plen[mq[0]]);
    check_status("ovf_drain");

    // wrap-around
    for (int n1 = 1; n1 <= 20; n1++) begin
      send_frame(n1, 1'b0, 1'b0);
      check_status("wrap");
      read_pkg(n1);
    end

    // truncation and saturated read pointer
    send_frame(300, 1'b0, 1'b0);
    check_status("trunc");
    id = mq[0];
    arm_open();
    chk("trunc_b0", int'(bus.buf_dat), int'(pdat[id][0]));
    for (int k = 1; k < 256; k++) begin
      arm_strobe();
      if (k == 255 || k % 64 == 0)
        chk($sformatf("trunc_b%0d", k), int'(bus.buf_dat), int'(pdat[id][k]));
    end
    arm_strobe();
    chk("trunc_sat", int'(bus.buf_dat), int'(pdat[id][255]));
    arm_close(1'b1);
    send_frame(0, 1'b0, 1'b0);
    check_status("empty_frm");

    // watchdog
    for (int i = 0; i < 3; i++) send_frame(3 + i, 1'b0, 1'b0);
    wd_pulse(1'b0);
    check_status("wd");
    id = mq[0];
    arm_open();
    wd_pulse(1'b1);
    check_status("wd_rd");
    arm_strobe();
    chk("wd_rd_b1", int'(bus.buf_dat), int'(pdat[id][1]));
    arm_close(1'b1);
    read_pkg(plen[mq[0]]);
    wd_pulse(1'b0);
    check_status("wd_empty");

    // commit coincident with discard
    send_frame(4, 1'b0, 1'b0);
    send_frame(6, 1'b1, 1'b0);
    check_status("cm_disc");
    read_pkg(6);

    // commit coincident with release
    send_frame(6, 1'b0, 1'b0);
    arm_open();
    id = next_id % 64;
    next_id++;
    @(negedge clk_sys);
    bus.repk_frm = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 5; i++) begin
      pdat[id][i]  = 8'($urandom);
      bus.repk_vld = 1'b1;
      bus.repk_dat = pdat[id][i];
      @(negedge clk_sys);
    end
    bus.repk_vld = 1'b0;
    bus.buf_frm  = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("cm_rel_pre", int'(bus.cnt_pkg_buf), 1);
    bus.repk_frm = 1'b0;
    @(negedge clk_sys);
    void'(mq.pop_front());
    plen[id] = 5;
    mq.push_back(id);
    check_status("cm_rel");
    read_pkg(5);

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(9);
      n  = $urandom_range(30);
      if (op <= 4)      send_frame(n, 1'b0, 1'b0);
      else if (op <= 7) read_pkg((mq.size() > 0) ? plen[mq[0]] : 1);
      else if (op == 8) wd_pulse(1'b0);
      else              send_frame(n, 1'b1, 1'b0);
      check_status($sformatf("rnd%0d", it));
    end

    // reset in the middle of a frame
    send_frame(5, 1'b0, 1'b0);
    send_frame(7, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) send_frame(2, 1'b0, 1'b0);
    @(negedge clk_sys);
    bus.repk_frm = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 4; i++) begin
      bus.repk_vld = 1'b1;
      bus.repk_dat = 8'($urandom);
      @(negedge clk_sys);
    end
    rst_n = 1'b0;
    #1;
    mq.delete();
    ovf_m = 0;
    chk("mid_rst_dat", int'(bus.buf_dat), 0);
    check_status("mid_rst");
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    bus.repk_frm = 1'b0;
    bus.repk_vld = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_status("post_rst");
    send_frame(4, 1'b0, 1'b1);
    check_status("post_rst_frm");
    read_pkg(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
